// File: rtl/loader_pkg.sv
// Shared types and sizing constants for the program loader.
// The loader streams bytes into 32-bit words and writes them to instruction memory.
package loader_pkg;

   localparam int DEFAULT_DEPTH  = 64;
   localparam int MAX_DEPTH      = 64;
   localparam int LEN_W          = 7;
   localparam int IDX_W          = 6;
   localparam int BYTES_PER_WORD = 4;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RECV  = 2'd1,
      WRITE = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Word index to byte address; the low two bits are always zero.
   function automatic logic [31:0] word_addr(input logic [IDX_W-1:0] idx);
      return {{(32-IDX_W-2){1'b0}}, idx, 2'b00};
   endfunction

endpackage

// File: rtl/word_assembler.sv
// Packs accepted bytes big-endian into a 32-bit word; the first byte lands in [31:24].
// word_next presents the complete word in the same cycle the fourth byte is accepted.
module word_assembler
   import loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        clear,
   input  logic        accept,
   input  logic [7:0]  byte_data,
   output logic        word_done,
   output logic [31:0] word_next
);

   localparam int LANES = BYTES_PER_WORD - 1;

   // lane_reg[0] holds the most recently accepted byte; older bytes move up.
   logic [7:0] lane_reg [LANES];
   logic [1:0] count_reg;

   always_ff @(posedge clk) begin
      if (!reset_n || clear) begin
         count_reg <= 2'd0;
      end else if (accept) begin
         count_reg <= count_reg + 2'd1;
      end
   end

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         if (gi == 0) begin : g_first
            always_ff @(posedge clk) begin
               if (!reset_n || clear) begin
                  lane_reg[gi] <= 8'd0;
               end else if (accept) begin
                  lane_reg[gi] <= byte_data;
               end
            end
         end else begin : g_shift
            always_ff @(posedge clk) begin
               if (!reset_n || clear) begin
                  lane_reg[gi] <= 8'd0;
               end else if (accept) begin
                  lane_reg[gi] <= lane_reg[gi-1];
               end
            end
         end
      end
   endgenerate

   assign word_done = accept && (count_reg == 2'd3);
   assign word_next = {lane_reg[2], lane_reg[1], lane_reg[0], byte_data};

endmodule

// File: rtl/prog_loader.sv
// Loads a program byte stream into word memory while holding the CPU in reset,
// then releases cpu_reset together with a one-cycle done pulse.
module prog_loader
   import loader_pkg::*;
#(
   parameter int DEPTH = DEFAULT_DEPTH
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start,
   input  logic [LEN_W-1:0]  len,
   input  logic              byte_valid,
   input  logic [7:0]        byte_data,
   output logic              byte_ready,
   output logic              mem_we,
   output logic [31:0]       mem_a,
   output logic [31:0]       mem_wd,
   output logic              cpu_reset,
   output logic              busy,
   output logic              done,
   output logic              err
);

   localparam logic [LEN_W-1:0] DEPTH_LEN = LEN_W'(DEPTH);

   state_t            state_reg;
   logic [LEN_W-1:0]  len_reg;
   logic [IDX_W-1:0]  index_reg;

   logic              len_ok;
   logic              take_start;
   logic              accept;
   logic              word_done;
   logic [31:0]       word_next;
   logic              last_word;

   assign len_ok     = (len != '0) && (len <= DEPTH_LEN);
   assign take_start = (state_reg == IDLE) && start && len_ok;
   // byte_ready is registered and high exactly while in RECV.
   assign accept     = byte_valid && byte_ready;
   assign last_word  = ({1'b0, index_reg} == (len_reg - LEN_W'(1)));

   word_assembler u_asm (
      .clk       (clk),
      .reset_n   (reset_n),
      .clear     (take_start),
      .accept    (accept),
      .byte_data (byte_data),
      .word_done (word_done),
      .word_next (word_next)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_reg  <= IDLE;
         len_reg    <= '0;
         index_reg  <= '0;
         byte_ready <= 1'b0;
         mem_we     <= 1'b0;
         mem_a      <= '0;
         mem_wd     <= '0;
         cpu_reset  <= 1'b1;
         busy       <= 1'b0;
         done       <= 1'b0;
         err        <= 1'b0;
      end else begin
         mem_we <= 1'b0;
         done   <= 1'b0;
         err    <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start) begin
                  if (len_ok) begin
                     len_reg    <= len;
                     index_reg  <= '0;
                     state_reg  <= RECV;
                     byte_ready <= 1'b1;
                     busy       <= 1'b1;
                     cpu_reset  <= 1'b1;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            RECV: begin
               if (word_done) begin
                  state_reg  <= WRITE;
                  byte_ready <= 1'b0;
                  mem_we     <= 1'b1;
                  mem_a      <= word_addr(index_reg);
                  mem_wd     <= word_next;
               end
            end
            WRITE: begin
               // len never exceeds DEPTH, so the index stops before it could wrap.
               if (last_word) begin
                  state_reg <= DONE;
                  busy      <= 1'b0;
                  done      <= 1'b1;
                  cpu_reset <= 1'b0;
               end else begin
                  index_reg  <= index_reg + IDX_W'(1);
                  state_reg  <= RECV;
                  byte_ready <= 1'b1;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: loads, bubbles, rejected starts, mid-load reset,
// full-depth load and starts issued while busy.
module tb_prog_loader;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        start;
   logic [6:0]  len;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        mem_we;
   logic [31:0] mem_a;
   logic [31:0] mem_wd;
   logic        cpu_reset;
   logic        busy;
   logic        done;
   logic        err;

   int tests = 0;
   int fails = 0;

   logic [31:0] wr_a [$];
   logic [31:0] wr_d [$];
   logic [7:0]  stream [$];
   int          cyc = 0;
   int          last_we_cyc = -10;
   int          done_cyc = -20;
   int          done_cnt = 0;
   int          err_cnt = 0;
   int          rdy_viol = 0;

   prog_loader dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .start      (start),
      .len        (len),
      .byte_valid (byte_valid),
      .byte_data  (byte_data),
      .byte_ready (byte_ready),
      .mem_we     (mem_we),
      .mem_a      (mem_a),
      .mem_wd     (mem_wd),
      .cpu_reset  (cpu_reset),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      #1;
      cyc++;
      if (mem_we) begin
         wr_a.push_back(mem_a);
         wr_d.push_back(mem_wd);
         last_we_cyc = cyc;
         if (byte_ready) rdy_viol++;
         $display("[TB] write a=0x%08h wd=0x%08h", mem_a, mem_wd);
      end
      if (done) begin
         done_cnt++;
         done_cyc = cyc;
      end
      if (err) err_cnt++;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(input logic [6:0] l);
      start = 1'b1;
      len   = l;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bubble);
      int t = 0;
      byte_valid = 1'b0;
      if (bubble) @(negedge clk);
      while (!byte_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
      byte_valid = 1'b1;
      byte_data  = b;
      @(negedge clk);
      byte_valid = 1'b0;
   endtask

   task automatic send_stream(input bit bubble);
      foreach (stream[i]) send_byte(stream[i], bubble);
   endtask

   // Leaves the bench at the negedge where done is high.
   task automatic wait_done();
      int t = 0;
      while (!done && t < 3000) begin
         @(negedge clk);
         t++;
      end
      check("done_seen", 32'(done), 32'd1);
      check("cpu_reset_with_done", 32'(cpu_reset), 32'd0);
      check("done_after_last_write", 32'(done_cyc), 32'(last_we_cyc + 1));
   endtask

   task automatic clear_log();
      wr_a.delete();
      wr_d.delete();
      done_cnt = 0;
      err_cnt  = 0;
   endtask

   task automatic load_stream(input logic [31:0] w0, input logic [31:0] w1);
      stream.delete();
      for (int k = 3; k >= 0; k--) stream.push_back(w0[8*k +: 8]);
      for (int k = 3; k >= 0; k--) stream.push_back(w1[8*k +: 8]);
   endtask

   initial begin
      logic [31:0] exp_w;
      reset_n    = 1'b0;
      start      = 1'b0;
      len        = 7'd0;
      byte_valid = 1'b0;
      byte_data  = 8'd0;
      repeat (3) @(negedge clk);

      // Reset state
      check("rst_byte_ready", 32'(byte_ready), 32'd0);
      check("rst_mem_we",     32'(mem_we),     32'd0);
      check("rst_busy",       32'(busy),       32'd0);
      check("rst_done",       32'(done),       32'd0);
      check("rst_err",        32'(err),        32'd0);
      check("rst_cpu_reset",  32'(cpu_reset),  32'd1);
      reset_n = 1'b1;
      @(negedge clk);

      // Two-word load without bubbles
      clear_log();
      load_stream(32'h20020005, 32'hAC020054);
      pulse_start(7'd2);
      check("start_busy",      32'(busy),       32'd1);
      check("start_ready",     32'(byte_ready), 32'd1);
      check("start_cpu_reset", 32'(cpu_reset),  32'd1);
      send_stream(1'b0);
      wait_done();
      @(negedge clk);
      check("l2_writes", 32'(wr_a.size()), 32'd2);
      if (wr_a.size() == 2) begin
         check("l2_a0", wr_a[0], 32'h0);
         check("l2_d0", wr_d[0], 32'h20020005);
         check("l2_a1", wr_a[1], 32'h4);
         check("l2_d1", wr_d[1], 32'hAC020054);
      end
      check("l2_done_cnt",   32'(done_cnt),  32'd1);
      check("l2_done_low",   32'(done),      32'd0);
      check("l2_idle_busy",  32'(busy),      32'd0);
      check("l2_cpu_rel",    32'(cpu_reset), 32'd0);

      // Same stream with a bubble before every byte
      clear_log();
      rdy_viol = 0;
      pulse_start(7'd2);
      send_stream(1'b1);
      wait_done();
      @(negedge clk);
      check("bub_writes", 32'(wr_a.size()), 32'd2);
      if (wr_a.size() == 2) begin
         check("bub_d0", wr_d[0], 32'h20020005);
         check("bub_a1", wr_a[1], 32'h4);
         check("bub_d1", wr_d[1], 32'hAC020054);
      end
      check("bub_ready_in_write", 32'(rdy_viol), 32'd0);

      // Rejected starts
      clear_log();
      pulse_start(7'd0);
      check("len0_err",  32'(err),  32'd1);
      check("len0_busy", 32'(busy), 32'd0);
      @(negedge clk);
      check("len0_err_pulse", 32'(err), 32'd0);
      pulse_start(7'd65);
      check("len65_err",   32'(err),        32'd1);
      check("len65_ready", 32'(byte_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("rej_err_cnt",   32'(err_cnt),     32'd2);
      check("rej_writes",    32'(wr_a.size()), 32'd0);
      check("rej_cpu_reset", 32'(cpu_reset),   32'd0);

      // Reset in the middle of the second word
      clear_log();
      load_stream(32'h01020304, 32'h05060708);
      pulse_start(7'd2);
      for (int i = 0; i < 6; i++) send_byte(stream[i], 1'b0);
      check("mid_first_write", 32'(wr_a.size()), 32'd1);
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      check("mid_cpu_reset", 32'(cpu_reset),  32'd1);
      check("mid_busy",      32'(busy),       32'd0);
      check("mid_ready",     32'(byte_ready), 32'd0);
      clear_log();
      byte_valid = 1'b1;
      byte_data  = 8'hEE;
      repeat (6) @(negedge clk);
      byte_valid = 1'b0;
      check("mid_no_writes", 32'(wr_a.size()), 32'd0);
      stream.delete();
      stream.push_back(8'h12);
      stream.push_back(8'h34);
      stream.push_back(8'h56);
      stream.push_back(8'h78);
      pulse_start(7'd1);
      send_stream(1'b0);
      wait_done();
      @(negedge clk);
      check("restart_writes", 32'(wr_a.size()), 32'd1);
      if (wr_a.size() == 1) begin
         check("restart_a", wr_a[0], 32'h0);
         check("restart_d", wr_d[0], 32'h12345678);
      end

      // Full-depth load
      clear_log();
      stream.delete();
      for (int i = 0; i < 256; i++) stream.push_back(8'(i));
      pulse_start(7'd64);
      send_stream(1'b0);
      wait_done();
      repeat (3) @(negedge clk);
      check("full_writes", 32'(wr_a.size()), 32'd64);
      if (wr_a.size() == 64) begin
         for (int k = 0; k < 64; k++) begin
            exp_w = {8'(4*k), 8'(4*k+1), 8'(4*k+2), 8'(4*k+3)};
            check($sformatf("full_a%0d", k), wr_a[k], 32'(4*k));
            check($sformatf("full_d%0d", k), wr_d[k], exp_w);
         end
         check("full_last_a", wr_a[63], 32'hFC);
      end
      check("full_done_cnt", 32'(done_cnt), 32'd1);

      // Starts while busy and during DONE are ignored
      clear_log();
      stream.delete();
      for (int i = 0; i < 12; i++) stream.push_back(8'(8'hA0 + i));
      pulse_start(7'd3);
      for (int i = 0; i < 2; i++) send_byte(stream[i], 1'b0);
      pulse_start(7'd1);
      check("busy_start_busy", 32'(busy), 32'd1);
      for (int i = 2; i < 12; i++) send_byte(stream[i], 1'b0);
      wait_done();
      pulse_start(7'd5);
      check("done_start_busy",  32'(busy),       32'd0);
      check("done_start_ready", 32'(byte_ready), 32'd0);
      repeat (3) @(negedge clk);
      check("busy_writes", 32'(wr_a.size()), 32'd3);
      if (wr_a.size() == 3) begin
         check("busy_d0", wr_d[0], 32'hA0A1A2A3);
         check("busy_a2", wr_a[2], 32'h8);
         check("busy_d2", wr_d[2], 32'hA8A9AAAB);
      end
      check("busy_done_cnt", 32'(done_cnt), 32'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Timing SHALL be: one clock; reset is synchronous and active-low.
REQ-002 Parameter DEPTH, default 64, SHALL set the memory size in 32-bit words (legal range 1..64).
REQ-003 Port clk, input, 1 bit, SHALL be the sole clock; all state updates on its rising edge.
REQ-004 Port reset_n, input, 1 bit, SHALL be the synchronous active-low reset.
REQ-005 Port start, input, 1 bit, SHALL request a load; sampled only in IDLE.
REQ-006 Port len, input, 7 bits, SHALL give the word count to load; sampled with start.
REQ-007 Port byte_valid, input, 1 bit, SHALL mark byte_data valid.
REQ-008 Port byte_data, input, 8 bits, SHALL carry the program byte stream.
REQ-009 Port byte_ready, output, 1 bit, SHALL indicate a byte is accepted this cycle when byte_valid is also high.
REQ-010 Port mem_we, output, 1 bit, SHALL be the memory write enable.
REQ-011 Port mem_a, output, 32 bits, SHALL be the byte address (word index << 2, bits[1:0]=0).
REQ-012 Port mem_wd, output, 32 bits, SHALL be the write data.
REQ-013 Port cpu_reset, output, 1 bit, SHALL hold the processor in reset while high.
REQ-014 Port busy, output, 1 bit, SHALL be high in RECV and WRITE.
REQ-015 Port done, output, 1 bit, SHALL pulse high for one cycle on load completion.
REQ-016 Port err, output, 1 bit, SHALL pulse high for one cycle on a rejected start.

Function
REQ-017 FSM states SHALL be IDLE, RECV, WRITE and DONE.
REQ-018 IDLE + start with 1<=len<=DEPTH: latch len, clear word index and byte count, go RECV, set cpu_reset=1.
REQ-019 IDLE + start with len==0 or len>DEPTH: pulse err, stay IDLE, issue no mem_we, leave cpu_reset unchanged.
REQ-020 byte_ready SHALL equal 1 only in RECV; it is independent of byte_valid.
REQ-021 Accepted bytes SHALL pack big-endian: 1st byte->[31:24], 2nd->[23:16], 3rd->[15:8], 4th->[7:0].
REQ-022 Accepting the 4th byte SHALL move the FSM to WRITE on the next edge; byte count wraps 3->0.
REQ-023 WRITE SHALL last exactly one cycle with mem_we=1, mem_a=index<<2, mem_wd=assembled word, byte_ready=0.
REQ-024 After WRITE: if index==len-1 go DONE, else increment index and return to RECV.
REQ-025 Word index SHALL never wrap; the last address SHALL be (DEPTH-1)*4.
REQ-026 DONE SHALL last one cycle with done=1 and cpu_reset=0, then go IDLE.
REQ-027 cpu_reset SHALL remain 0 in IDLE after a successful load, until the next accepted start.
REQ-028 start in RECV, WRITE or DONE SHALL be ignored.
REQ-029 Bubbles on byte_valid SHALL only stall assembly; they SHALL NOT corrupt it.
REQ-030 mem_we SHALL be 0 in every state except WRITE; mem_a and mem_wd are don't-care when mem_we=0.

Reset
REQ-031 reset_n=0 SHALL force: state IDLE, byte_ready 0, mem_we 0, busy 0, done 0, err 0, cpu_reset 1, index 0, byte count 0.
REQ-032 Reset mid-load SHALL discard the partial word, issue no further writes, and require a new start.

Structure
REQ-033 Package loader_pkg SHALL hold the state enum typedef and the default DEPTH constant.
REQ-034 Sub-module word_assembler (byte counter plus 32-bit shift register, with clear input) is the natural split; all other logic stays in prog_loader.

Verification
REQ-035 len=2, bytes 20 02 00 05 AC 02 00 54 -> writes (a=0x0, wd=0x20020005), then (a=0x4, wd=0xAC020054); done pulses the cycle after the 2nd write; cpu_reset falls with done.
REQ-036 Same stream with byte_valid low every other cycle -> identical writes; byte_ready=0 during each WRITE cycle.
REQ-037 start with len=0, then len=65 -> one err pulse each, mem_we never high, state stays IDLE.
REQ-038 reset_n low for one cycle after 6 accepted bytes -> no mem_we and cpu_reset=1; a restart with len=1 and bytes 12 34 56 78 -> write (a=0x0, wd=0x12345678).
REQ-039 len=64, 256 bytes -> 64 writes, last at a=0xFC, no write to 0x100, a single done pulse.
REQ-040 start pulsed while busy -> ignored; write count equals the original len.
